// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Used by the register file and its read ports.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RF_ENTRIES = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    CLEAR,
    READY
  } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Applies clear masking, hard-wired zero register and write-to-read bypass.
module rf_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  rf_state_t         state,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  array_data,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [WIDTH-1:0]  writedata,
  output logic [WIDTH-1:0]  data
);

  always_comb begin
    data = '0;
    // addr != 0 also guarantees the bypass never forwards a write to r0
    if (state == READY && addr != '0) begin
      if (BYPASS != 0 && regwrite && writereg == addr) begin
        data = writedata;
      end else begin
        data = array_data;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write MIPS register file with a post-reset clear sequencer
// that zeroes every entry before the core may use it.
module register_file
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              regwrite,
  output logic [WIDTH-1:0]  readdata1,
  output logic [WIDTH-1:0]  readdata2,
  output logic              busy
);

  localparam int ENTRIES = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [ENTRIES];
  rf_state_t         state;
  rf_state_t         state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              ptr_last;

  assign ptr_last = (ptr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (state == CLEAR) begin
      // ptr wraps to 0 on the last clear edge; the value is unused in READY
      ptr_next = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (ptr_last) begin
        state_next = READY;
      end
    end
  end

  // Array is never reset; reset only restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (regwrite && writereg != '0) begin
        mem[writereg] <= writedata;
      end
    end
  end

  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  rdata [2];

  assign raddr[0] = readreg1;
  assign raddr[1] = readreg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      rf_read_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
      ) u_port (
        .state      (state),
        .addr       (raddr[gi]),
        .array_data (mem[raddr[gi]]),
        .regwrite   (regwrite),
        .writereg   (writereg),
        .writedata  (writedata),
        .data       (rdata[gi])
      );
    end
  endgenerate

  assign readdata1 = rdata[0];
  assign readdata2 = rdata[1];
  assign busy      = (state == CLEAR);

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one bypassing and one non-bypassing
// instance share the same stimulus and are checked against hand-derived values.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  readreg1, readreg2, writereg;
  logic [31:0] writedata;
  logic        regwrite;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy_b, busy_n;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
    .readdata1(rd1_b), .readdata2(rd2_b), .busy(busy_b)
  );

  register_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
    .readdata1(rd1_n), .readdata2(rd2_n), .busy(busy_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1_b;
    logic [31:0] e2_b;
    logic [31:0] e1_n;
    logic [31:0] e2_n;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy falls on both instances, bounded.
  task automatic count_clear(input string name, input int wr_at_a, input int wr_at_b);
    int n = 0;
    while ((busy_b || busy_n) && n < 100) begin
      regwrite  = (n == wr_at_a) || (n == wr_at_b);
      writereg  = (n == wr_at_a) ? 5'd3 : 5'd4;
      writedata = (n == wr_at_a) ? 32'h0000_AAAA : 32'h0000_5555;
      readreg1  = 5'd3;
      readreg2  = 5'd4;
      #1;
      if (n == wr_at_a) begin
        check({name, "_clear_rd1_b"}, rd1_b, 32'h0);
        check({name, "_clear_rd1_n"}, rd1_n, 32'h0);
      end
      step();
      n++;
    end
    regwrite = 1'b0;
    $display("%s: busy held for %0d edges", name, n);
    check({name, "_clear_len"}, n, 32'd32);
  endtask

  initial begin
    rst = 1'b1; regwrite = 1'b0; writereg = '0; writedata = '0;
    readreg1 = '0; readreg2 = '0;

    // Reset held for two edges
    step();
    check("rst_busy_b", {31'b0, busy_b}, 32'd1);
    check("rst_busy_n", {31'b0, busy_n}, 32'd1);
    step();
    check("rst_rd1", rd1_b, 32'h0);
    check("rst_rd2", rd2_b, 32'h0);
    rst = 1'b0;

    // Clear sequence; write to r3 at clear cycle 10 and r4 on the last clear edge are ignored
    count_clear("clear1", 10, 31);
    check("ready_busy_b", {31'b0, busy_b}, 32'd0);
    check("ready_busy_n", {31'b0, busy_n}, 32'd0);

    vecs[0]  = '{1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd7, 32'h0,         5'd7, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd5, 32'h1234, 32'h1234, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 32'h1234, 32'h1234, 32'h1234, 32'h1234};
    vecs[7]  = '{1'b1, 5'd1, 32'h1,         5'd1, 5'd2, 32'h1, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 5'd2, 32'h2,         5'd1, 5'd2, 32'h1, 32'h2, 32'h1, 32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,         5'd1, 5'd2, 32'h1, 32'h2, 32'h1, 32'h2};
    vecs[10] = '{1'b1, 5'd5, 32'hCAFE,      5'd5, 5'd1, 32'hCAFE, 32'h1, 32'h1234, 32'h1};
    vecs[11] = '{1'b0, 5'd5, 32'h9,         5'd5, 5'd5, 32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE};
    vecs[12] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd5, 32'hDEAD_BEEF, 32'hCAFE, 32'hDEAD_BEEF, 32'hCAFE};

    for (int i = 0; i < 13; i++) begin
      regwrite  = vecs[i].we;
      writereg  = vecs[i].wa;
      writedata = vecs[i].wd;
      readreg1  = vecs[i].ra1;
      readreg2  = vecs[i].ra2;
      #1;
      $display("vec %0d: we=%0b wa=%0d wd=%h ra=%0d/%0d byp=%h/%h nobyp=%h/%h",
               i, regwrite, writereg, writedata, readreg1, readreg2, rd1_b, rd2_b, rd1_n, rd2_n);
      check($sformatf("vec%0d_rd1_b", i), rd1_b, vecs[i].e1_b);
      check($sformatf("vec%0d_rd2_b", i), rd2_b, vecs[i].e2_b);
      check($sformatf("vec%0d_rd1_n", i), rd1_n, vecs[i].e1_n);
      check($sformatf("vec%0d_rd2_n", i), rd2_n, vecs[i].e2_n);
      check($sformatf("vec%0d_busy", i), {31'b0, busy_b}, 32'd0);
      step();
    end
    regwrite = 1'b0;

    // Reset during a READY write: the write is dropped and clearing starts
    rst = 1'b1; regwrite = 1'b1; writereg = 5'd9; writedata = 32'h99;
    step();
    rst = 1'b0; regwrite = 1'b0;
    check("midwr_busy", {31'b0, busy_b}, 32'd1);
    for (int k = 0; k < 20; k++) step();
    check("midclr_busy_pre", {31'b0, busy_b}, 32'd1);

    // Reset for one edge at clear cycle 20 restarts the full clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("clear2", -1, -1);

    readreg1 = 5'd7; readreg2 = 5'd5;
    #1;
    check("reclr_r7_b", rd1_b, 32'h0);
    check("reclr_r5_b", rd2_b, 32'h0);
    check("reclr_r7_n", rd1_n, 32'h0);
    readreg1 = 5'd9; readreg2 = 5'd1;
    #1;
    check("reclr_r9", rd1_b, 32'h0);
    check("reclr_r1", rd2_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
